// File: rtl/sfp_accum.sv
// sfp_accum: per-column saturating psum accumulator with optional ReLU and valid/ready output
module sfp_accum #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int cnt_bw  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [col*psum_bw-1:0]   in_psum,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     acc_clear,
    input  logic [cnt_bw-1:0]        num_pass,
    input  logic                     relu_en,
    output logic [col*psum_bw-1:0]   out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [col-1:0]           sat_flag
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;
    localparam logic [psum_bw-1:0] MAX_V = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic [psum_bw-1:0] MIN_V = {1'b1, {(psum_bw-1){1'b0}}};

    logic [1:0]               state_q, state_d;
    logic [col*psum_bw-1:0]   acc_q, acc_d;
    logic [cnt_bw-1:0]        cnt_q, cnt_d;
    logic [cnt_bw-1:0]        npass_q, npass_d;
    logic [col*psum_bw-1:0]   out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic [col-1:0]           sat_q, sat_d;
    logic [col*psum_bw-1:0]   sum_sat;
    logic [col*psum_bw-1:0]   relu_val;
    logic [col-1:0]           hit;
    logic                     accept;
    logic                     last;

    assign in_ready  = (state_q == S_ACC) && !acc_clear;
    assign accept    = in_valid && in_ready;
    assign last      = cnt_q == npass_q - cnt_bw'(1);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign sat_flag  = sat_q;

    for (genvar g = 0; g < col; g++) begin : g_lane
        logic [psum_bw:0] ext;
        assign ext = {acc_q[g*psum_bw+psum_bw-1], acc_q[g*psum_bw +: psum_bw]}
                   + {in_psum[g*psum_bw+psum_bw-1], in_psum[g*psum_bw +: psum_bw]};
        assign hit[g] = ext[psum_bw] ^ ext[psum_bw-1];
        assign sum_sat[g*psum_bw +: psum_bw] = hit[g] ? (ext[psum_bw] ? MIN_V : MAX_V) : ext[psum_bw-1:0];
        assign relu_val[g*psum_bw +: psum_bw] = (relu_en && sum_sat[g*psum_bw+psum_bw-1]) ? '0 : sum_sat[g*psum_bw +: psum_bw];
    end

    // next state: clear beats accept, accept beats output handshake
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        npass_d     = npass_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        sat_d       = sat_q;
        if (acc_clear) begin
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            sat_d       = '0;
            npass_d     = (num_pass == '0) ? cnt_bw'(1) : num_pass;
            state_d     = S_ACC;
        end else if (accept) begin
            acc_d = sum_sat;
            sat_d = sat_q | hit;
            cnt_d = last ? '0 : cnt_q + cnt_bw'(1);
            if (last) begin
                out_data_d  = relu_val;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = S_ACC;
        end
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            npass_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            npass_q     <= npass_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
        end
    end
endmodule
